// File: rtl/sr_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | sr_pulse_gen                                                               |
// | Turns two bouncing pushbuttons into mutually exclusive fixed-width S/R     |
// | pulses for a NOR SR latch and tracks the latch state it should now hold.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module sr_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_set,
  input  logic btn_reset,
  output logic S,
  output logic R,
  output logic busy,
  output logic q_expect,
  output logic dropped
);

  localparam int c_DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_PW = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam logic [c_DW-1:0] c_D_MAX = c_DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_PW-1:0] c_P_MAX = c_PW'(PULSE_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_SET_P = 3'd2,
    ST_RST_P = 3'd3,
    ST_GUARD = 3'd4
  } state_t;

  // Channel 0 is set, channel 1 is reset.
  logic [1:0] w_btn;
  logic [1:0] w_rise;
  assign w_btn = {btn_reset, btn_set};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    logic            r_sync1;
    logic            r_sync2;
    logic            r_stable;
    logic            r_stable_q;
    logic [c_DW-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_sync1    <= 1'b0;
        r_sync2    <= 1'b0;
        r_stable   <= 1'b0;
        r_stable_q <= 1'b0;
        r_cnt      <= '0;
      end else begin
        r_sync1    <= w_btn[gi];
        r_sync2    <= r_sync1;
        r_stable_q <= r_stable;
        if (r_sync2 != r_stable) begin
          if (r_cnt == c_D_MAX) begin
            r_stable <= r_sync2;
            r_cnt    <= '0;
          end else begin
            r_cnt <= r_cnt + c_DW'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end
    end

    // Only a press is a request; a release is just debounced back to idle.
    assign w_rise[gi] = r_stable & ~r_stable_q;
  end

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_PW-1:0] r_pcnt;
  logic [c_PW-1:0] w_pcnt_nxt;
  logic [1:0]      r_pend;
  logic [1:0]      w_clr;
  logic            w_drop;
  logic            r_s;
  logic            r_r;
  logic            r_busy;
  logic            r_q;
  logic            w_q_nxt;
  logic            r_dropped;

  always_comb begin
    w_state_nxt = r_state;
    w_pcnt_nxt  = r_pcnt;
    w_clr       = 2'b00;
    w_q_nxt     = r_q;
    case (r_state)
      ST_INIT, ST_SET_P, ST_RST_P: begin
        if (r_pcnt == c_P_MAX) begin
          w_state_nxt = ST_GUARD;
          w_pcnt_nxt  = '0;
          if (r_state == ST_SET_P) begin
            w_q_nxt = 1'b1;
          end else if (r_state == ST_RST_P) begin
            w_q_nxt = 1'b0;
          end
        end else begin
          w_pcnt_nxt = r_pcnt + c_PW'(1);
        end
      end
      ST_IDLE: begin
        w_pcnt_nxt = '0;
        if (r_pend[1]) begin
          w_state_nxt = ST_RST_P;
          w_clr[1]    = 1'b1;
        end else if (r_pend[0]) begin
          w_state_nxt = ST_SET_P;
          w_clr[0]    = 1'b1;
        end
      end
      ST_GUARD: begin
        w_state_nxt = ST_IDLE;
        w_pcnt_nxt  = '0;
      end
      default: begin
        w_state_nxt = ST_INIT;
        w_pcnt_nxt  = '0;
      end
    endcase
  end

  // A press arriving while its channel is still pending is lost.
  assign w_drop = |(w_rise & r_pend & ~w_clr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_INIT;
      r_pcnt    <= '0;
      r_pend    <= 2'b00;
      r_s       <= 1'b0;
      r_r       <= 1'b1;
      r_busy    <= 1'b1;
      r_q       <= 1'b0;
      r_dropped <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_pend    <= (r_pend & ~w_clr) | w_rise;
      r_s       <= (w_state_nxt == ST_SET_P);
      r_r       <= (w_state_nxt == ST_RST_P) || (w_state_nxt == ST_INIT);
      r_busy    <= (w_state_nxt != ST_IDLE);
      r_q       <= w_q_nxt;
      r_dropped <= w_drop;
    end
  end

  assign S        = r_s;
  assign R        = r_r;
  assign busy     = r_busy;
  assign q_expect = r_q;
  assign dropped  = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_sr_pulse_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_sr_pulse_gen                                                            |
// | Two instances (short and long pulse) driven by shared random/directed      |
// | button stimulus and compared against a schedule-based reference model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_sr_pulse_gen;

  localparam int c_DB = 4;
  localparam int c_P0 = 2;
  localparam int c_P1 = 12;

  logic       clk       = 1'b0;
  logic       rst_n     = 1'b0;
  logic       btn_set   = 1'b0;
  logic       btn_reset = 1'b0;
  logic [1:0] w_s, w_r, w_busy, w_q, w_drop;

  always #5 clk = ~clk;

  sr_pulse_gen #(.DEBOUNCE_CYCLES(c_DB), .PULSE_CYCLES(c_P0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
    .S(w_s[0]), .R(w_r[0]), .busy(w_busy[0]), .q_expect(w_q[0]), .dropped(w_drop[0])
  );

  sr_pulse_gen #(.DEBOUNCE_CYCLES(c_DB), .PULSE_CYCLES(c_P1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .btn_set(btn_set), .btn_reset(btn_reset),
    .S(w_s[1]), .R(w_r[1]), .busy(w_busy[1]), .q_expect(w_q[1]), .dropped(w_drop[1])
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Button conditioning is identical for both instances; index is channel.
  int m_s1[2], m_s2[2], m_stable[2], m_run[2], m_rise[2];
  // Per-instance request and output schedule. Entry codes:
  // 0 idle, 1 S high, 2 R high, 3 guard then q=1, 4 guard then q=0, 5 guard keep q.
  int m_pend[2][2];
  int m_sched[2][$];
  int m_S[2], m_R[2], m_busy[2], m_q[2], m_drop[2];

  // Statistics over a directed window, from observed outputs.
  int prev_s[2], prev_r[2], s_rises[2], r_rises[2], s_hi[2], r_hi[2];
  int first_s[2], first_r[2], drop_cnt[2];

  function automatic int pulse_len(input int k);
    return (k == 0) ? c_P0 : c_P1;
  endfunction

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_s1[ch] = 0; m_s2[ch] = 0; m_stable[ch] = 0; m_run[ch] = 0; m_rise[ch] = 0;
    end
    for (int k = 0; k < 2; k++) begin
      m_sched[k].delete();
      for (int i = 0; i < pulse_len(k) - 1; i++) m_sched[k].push_back(2);
      m_sched[k].push_back(5);
      m_sched[k].push_back(0);
      m_pend[k][0] = 0; m_pend[k][1] = 0;
      m_S[k] = 0; m_R[k] = 1; m_busy[k] = 1; m_q[k] = 0; m_drop[k] = 0;
    end
  endtask

  task automatic schedule(input int k, input int pulse_code, input int guard_code);
    for (int i = 0; i < pulse_len(k); i++) m_sched[k].push_back(pulse_code);
    m_sched[k].push_back(guard_code);
    m_sched[k].push_back(0);
  endtask

  task automatic model_edge(input int bs, input int br);
    int code;
    int clr[2];
    int rise_nxt[2];
    int b[2];
    b[0] = bs; b[1] = br;
    for (int k = 0; k < 2; k++) begin
      clr[0] = 0; clr[1] = 0;
      if (m_sched[k].size() == 0) begin
        if (m_pend[k][1] != 0) begin
          schedule(k, 2, 4); clr[1] = 1;
        end else if (m_pend[k][0] != 0) begin
          schedule(k, 1, 3); clr[0] = 1;
        end
      end
      m_drop[k] = 0;
      for (int ch = 0; ch < 2; ch++) begin
        if (m_rise[ch] != 0 && m_pend[k][ch] != 0 && clr[ch] == 0) m_drop[k] = 1;
        m_pend[k][ch] = (clr[ch] != 0) ? m_rise[ch] : (m_pend[k][ch] | m_rise[ch]);
      end
      code = (m_sched[k].size() > 0) ? m_sched[k].pop_front() : 0;
      m_S[k]    = (code == 1) ? 1 : 0;
      m_R[k]    = (code == 2) ? 1 : 0;
      m_busy[k] = (code != 0) ? 1 : 0;
      if (code == 3) m_q[k] = 1;
      else if (code == 4) m_q[k] = 0;
    end
    for (int ch = 0; ch < 2; ch++) begin
      rise_nxt[ch] = 0;
      if (m_s2[ch] != m_stable[ch]) begin
        m_run[ch]++;
        if (m_run[ch] == c_DB) begin
          m_stable[ch] = m_s2[ch];
          m_run[ch]    = 0;
          rise_nxt[ch] = m_stable[ch];
        end
      end else begin
        m_run[ch] = 0;
      end
      m_rise[ch] = rise_nxt[ch];
      m_s2[ch]   = m_s1[ch];
      m_s1[ch]   = b[ch];
    end
  endtask

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check_eq($sformatf("S[%0d]", k),        int'(w_s[k]),    m_S[k]);
      check_eq($sformatf("R[%0d]", k),        int'(w_r[k]),    m_R[k]);
      check_eq($sformatf("busy[%0d]", k),     int'(w_busy[k]), m_busy[k]);
      check_eq($sformatf("q_expect[%0d]", k), int'(w_q[k]),    m_q[k]);
      check_eq($sformatf("dropped[%0d]", k),  int'(w_drop[k]), m_drop[k]);
      check_eq($sformatf("s_and_r[%0d]", k),  int'(w_s[k] & w_r[k]), 0);
    end
  endtask

  task automatic clear_stats();
    cyc = 0;
    for (int k = 0; k < 2; k++) begin
      prev_s[k] = int'(w_s[k]); prev_r[k] = int'(w_r[k]);
      s_rises[k] = 0; r_rises[k] = 0; s_hi[k] = 0; r_hi[k] = 0;
      first_s[k] = -1; first_r[k] = -1; drop_cnt[k] = 0;
    end
  endtask

  task automatic step(input logic bs, input logic br);
    btn_set   = bs;
    btn_reset = br;
    @(posedge clk);
    if (rst_n) model_edge(int'(bs), int'(br));
    #1;
    compare_all();
    for (int k = 0; k < 2; k++) begin
      if (w_s[k]) begin
        s_hi[k]++;
        if (prev_s[k] == 0) begin
          s_rises[k]++;
          if (first_s[k] < 0) first_s[k] = cyc;
        end
      end
      if (w_r[k]) begin
        r_hi[k]++;
        if (prev_r[k] == 0) begin
          r_rises[k]++;
          if (first_r[k] < 0) first_r[k] = cyc;
        end
      end
      if (w_drop[k]) drop_cnt[k]++;
      prev_s[k] = int'(w_s[k]);
      prev_r[k] = int'(w_r[k]);
    end
    cyc++;
  endtask

  task automatic pulse_reset(input int n);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    repeat (n) step(1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    logic bs, br;
    int   kind, w, hit;

    // Power-up reset: three cycles low, then release.
    model_reset();
    repeat (3) step(1'b0, 1'b0);
    rst_n = 1'b1;
    clear_stats();
    repeat (6) step(1'b0, 1'b0);
    check_eq("init_r_cycles", r_hi[0], c_P0 - 1);
    check_eq("init_busy_end", int'(w_busy[0]), 0);
    check_eq("init_q", int'(w_q[0]), 0);
    repeat (20) step(1'b0, 1'b0);

    // Clean set press held from edge 0.
    clear_stats();
    repeat (20) step(1'b1, 1'b0);
    repeat (12) step(1'b0, 1'b0);
    check_eq("clean_first_s_edge", first_s[0], 3 + c_DB);
    check_eq("clean_s_cycles", s_hi[0], c_P0);
    check_eq("clean_r_cycles", r_hi[0], 0);
    check_eq("clean_q", int'(w_q[0]), 1);
    repeat (30) step(1'b0, 1'b0);

    // Bounce: toggling every 2 cycles never satisfies the debounce.
    clear_stats();
    for (int i = 0; i < 20; i++) step(((i / 2) % 2) == 0, 1'b0);
    repeat (20) step(1'b0, 1'b0);
    check_eq("bounce_s_rises0", s_rises[0], 0);
    check_eq("bounce_s_rises1", s_rises[1], 0);
    check_eq("bounce_drops", drop_cnt[0] + drop_cnt[1], 0);

    // Both buttons together: reset served first, then set.
    clear_stats();
    repeat (8) step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b0);
    check_eq("simul_r_before_s", (first_r[0] >= 0 && first_r[0] < first_s[0]) ? 1 : 0, 1);
    check_eq("simul_s_rises", s_rises[0], 1);
    check_eq("simul_r_cycles", r_hi[0], c_P0);
    check_eq("simul_q", int'(w_q[0]), 1);
    repeat (20) step(1'b0, 1'b0);

    // Two set presses while instance 1 is still in its long reset pulse.
    clear_stats();
    for (int i = 0; i < 70; i++)
      step((i >= 1 && i <= 6) || (i >= 13 && i <= 18), i <= 5);
    check_eq("pend_drop_long", drop_cnt[1], 1);
    check_eq("pend_s_rises_long", s_rises[1], 1);
    check_eq("pend_drop_short", drop_cnt[0], 0);
    check_eq("pend_s_rises_short", s_rises[0], 2);
    check_eq("pend_q_long", int'(w_q[1]), 1);

    // Reset while S is high.
    hit = 0;
    for (int i = 0; i < 40 && hit == 0; i++) begin
      step(1'b1, 1'b0);
      if (w_s[0]) hit = 1;
    end
    check_eq("mid_reach_s", hit, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("mid_rst_s", int'(w_s[0]), 0);
    check_eq("mid_rst_r", int'(w_r[0]), 1);
    check_eq("mid_rst_q", int'(w_q[0]), 0);
    compare_all();
    repeat (2) step(1'b0, 1'b0);
    rst_n = 1'b1;
    clear_stats();
    repeat (30) step(1'b0, 1'b0);
    check_eq("mid_no_stale_s", s_rises[0] + s_rises[1], 0);

    // Randomised traffic against the model.
    for (int seg = 0; seg < 300; seg++) begin
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: repeat ($urandom_range(1, 20)) step(1'b0, 1'b0);
        1: begin
          bs = 1'($urandom_range(0, 1));
          br = 1'($urandom_range(0, 1));
          if (!bs && !br) bs = 1'b1;
          repeat ($urandom_range(c_DB, 14)) step(bs, br);
        end
        2: begin
          w = int'($urandom_range(1, c_DB - 1));
          repeat ($urandom_range(2, 8)) begin
            bs = 1'($urandom_range(0, 1));
            repeat (w) step(bs, ~bs);
            repeat (w) step(1'b0, 1'b0);
          end
        end
        3: repeat (10) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        default: begin
          if ($urandom_range(0, 9) == 0) pulse_reset(int'($urandom_range(1, 3)));
          else step(1'b0, 1'b0);
        end
      endcase
    end
    repeat (40) step(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
